mux_rr_stream: RTL

- Parametrised successor to the team's gate-level 4:1 mux.
- Selects one of NUM_CH WIDTH-bit streaming channels onto a single registered output.
- Two modes:
  - fixed-select: channel chosen by sel_in.
  - round-robin: fair arbitration among requesting channels.
- Every input channel and the output use a valid/ready handshake. The block sits between parallel producers and a single downstream consumer.

---
 rtl/mux_rr_stream.sv | 63 ++++++
 1 files changed

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: NUM_CH-way valid/ready stream mux, fixed-select or round-robin, registered output
module mux_rr_stream #(
    parameter int WIDTH = 8,
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       valid_in,
    output logic [NUM_CH-1:0]       ready_out,
    input  logic                    mode_in,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [SEL_W-1:0]        ch_out,
    input  logic                    ready_in
);
    logic [SEL_W-1:0] ptr, idx, rr_gnt, gnt;
    logic             rr_vld, gnt_vld, load_en, take;

    assign load_en = !valid_out || ready_in;

    // round-robin: first valid channel after ptr; descending scan so the nearest one wins
    always_comb begin
        rr_gnt = '0;
        rr_vld = 1'b0;
        idx    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = SEL_W'((int'(ptr) + i) % NUM_CH);
            if (valid_in[idx]) begin
                rr_gnt = idx;
                rr_vld = 1'b1;
            end
        end
    end

    assign gnt     = mode_in ? rr_gnt : sel_in;
    assign gnt_vld = mode_in ? rr_vld : (int'(sel_in) < NUM_CH) && valid_in[sel_in];
    assign take    = load_en && gnt_vld;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_rdy
        assign ready_out[k] = rst_n_in && take && (gnt == SEL_W'(k));
    end

    // output register: load on grant, clear valid on drain, hold on stall
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            ch_out    <= '0;
            ptr       <= SEL_W'(NUM_CH - 1);
        end else if (take) begin
            data_out  <= data_in[gnt*WIDTH +: WIDTH];
            valid_out <= 1'b1;
            ch_out    <= gnt;
            if (mode_in)
                ptr <= gnt;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end
endmodule
